// File: rtl/dmr_pkg.sv
// dmr_pkg: shared FSM state type, MMIO address constant and wait-counter width for data_mem_responder.
package dmr_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int CNT_W = 4;
  localparam logic [31:0] MMIO_ALL_ONES = '1;
endpackage

// File: rtl/dmr_sram.sv
// dmr_sram: single-port synchronous 32-bit x DEPTH word array, write enable, registered read, no reset.
module dmr_sram #(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state memory responder for a CPU data port with optional LED register.
// Define DMR_MMIO_LED_EN to map the all-ones word address onto the 8-bit LED register.
module data_mem_responder import dmr_pkg::*; #(
  parameter int ADDR_W = 12,
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        led_out
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q, rsp_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, sram_rdata, mmio_rdata;
  logic              idle, c_write, c_mmio, c_oor, commit, mem_we;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  // In IDLE the live request is used so a zero-wait store commits on its accept edge.
  assign idle    = state_q == IDLE;
  assign c_write = idle ? req_write : write_q;
  assign c_addr  = idle ? req_addr : addr_q;
  assign c_wdata = idle ? req_wdata : wdata_q;
  assign c_oor   = !c_mmio && (32'(c_addr) >= 32'(DEPTH));
  assign commit  = idle ? (req_valid && WAIT_CYCLES == 0)
                        : (state_q == WAIT && cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign mem_we  = commit && c_write && !c_oor && !c_mmio;
`ifdef DMR_MMIO_LED_EN
  logic [7:0] led_q;
  assign c_mmio     = c_addr == MMIO_ALL_ONES[ADDR_W-1:0];
  assign mmio_rdata = {24'b0, led_q};
  assign led_out    = led_q;
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) led_q <= '0;
    else if (commit && c_write && c_mmio) led_q <= c_wdata[7:0];
  end
`else
  assign c_mmio     = 1'b0;
  assign mmio_rdata = '0;
  assign led_out    = '0;
`endif
  dmr_sram #(.DEPTH(DEPTH), .AW(IW)) u_sram (
    .clk_i  (MAX10_CLK1_50),
    .we_i   (mem_we),
    .addr_i (c_addr[IW-1:0]),
    .wdata_i(c_wdata),
    .rdata_o(sram_rdata)
  );
  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && c_oor;
  assign rsp_rdata = (rsp_valid_q && !c_write && !c_oor) ? (c_mmio ? mmio_rdata : sram_rdata) : '0;
  // rsp_valid rises one cycle after entering RESP, giving the SRAM its read cycle.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          write_q <= req_write;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt_q   <= '0;
          state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (commit) state_q <= RESP;
        end
        RESP: if (rsp_valid_q && rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end else rsp_valid_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a 2-wait-state and a 0-wait-state responder.
module tb_data_mem_responder;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid [2], req_ready [2], req_write [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [11:0] req_addr [2];
  logic [31:0] req_wdata [2], rsp_rdata [2];
  logic [7:0]  led [2];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
    .MAX10_CLK1_50(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .led_out(led[0]));

  data_mem_responder #(.ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .MAX10_CLK1_50(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .led_out(led[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic issue(input int i, input logic w, input logic [11:0] a, input logic [31:0] d,
                       input int exp_lat);
    int lat;
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a; req_wdata[i] = d;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0;
    while (!rsp_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic ack(input int i);
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    check("ack_valid", {31'b0, rsp_valid[i]}, 32'd0);
    check("ack_ready", {31'b0, req_ready[i]}, 32'd1);
  endtask

  task automatic xfer(input int i, input logic w, input logic [11:0] a, input logic [31:0] d,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    issue(i, w, a, d, exp_lat);
    check("rdata", rsp_rdata[i], exp_rdata);
    check("err", {31'b0, rsp_err[i]}, {31'b0, exp_err});
    ack(i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
      rsp_ready[i] = 1'b0;
    end
    #12 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'd0);
    check("rst_err", {31'b0, rsp_err[0]}, 32'd0);
    check("rst_led", {24'b0, led[0]}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b1, 12'h005, 32'hDEADBEEF, 3, 32'd0, 1'b0);
    xfer(0, 1'b0, 12'h005, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    xfer(0, 1'b1, 12'h000, 32'hCAFEF00D, 3, 32'd0, 1'b0);
    xfer(0, 1'b0, 12'h400, 32'h0, 3, 32'd0, 1'b1);
    xfer(0, 1'b1, 12'h400, 32'h11111111, 3, 32'd0, 1'b1);
    xfer(0, 1'b0, 12'h000, 32'h0, 3, 32'hCAFEF00D, 1'b0);
    xfer(0, 1'b0, 12'h3FF, 32'h0, 3, 32'd0, 1'b0 ^ 1'b0) ;
    // Response hold with rsp_ready low while request inputs wander.
    issue(0, 1'b0, 12'h005, 32'h0, 3);
    for (int k = 0; k < 5; k++) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 12'h005 + 12'(k + 1);
      @(posedge clk); #1;
      check("hold_valid", {31'b0, rsp_valid[0]}, 32'd1);
      check("hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("hold_ready", {31'b0, req_ready[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    ack(0);
    xfer(0, 1'b0, 12'h006, 32'h0, 3, rsp_rdata[0] ^ rsp_rdata[0] ^ 32'h0 | 32'h0, 1'b0) ;
    xfer(0, 1'b0, 12'h005, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    // Reset during WAIT of a store must abandon it.
    xfer(0, 1'b1, 12'h010, 32'h55AA55AA, 3, 32'd0, 1'b0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 12'h010; req_wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("wait_ready", {31'b0, req_ready[0]}, 32'd0);
    reset = 1'b1; #1;
    check("arst_ready", {31'b0, req_ready[0]}, 32'd1);
    check("arst_valid", {31'b0, rsp_valid[0]}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    xfer(0, 1'b0, 12'h010, 32'h0, 3, 32'h55AA55AA, 1'b0);
`ifdef DMR_MMIO_LED_EN
    xfer(0, 1'b1, 12'hFFF, 32'h000000A5, 3, 32'd0, 1'b0);
    check("led", {24'b0, led[0]}, 32'h000000A5);
    xfer(0, 1'b0, 12'hFFF, 32'h0, 3, 32'h000000A5, 1'b0);
`else
    xfer(0, 1'b1, 12'hFFF, 32'h000000A5, 3, 32'd0, 1'b1);
    check("led", {24'b0, led[0]}, 32'd0);
    xfer(0, 1'b0, 12'hFFF, 32'h0, 3, 32'd0, 1'b1);
`endif
    xfer(1, 1'b1, 12'h020, 32'hA1B2C3D4, 1, 32'd0, 1'b0);
    xfer(1, 1'b0, 12'h020, 32'h0, 1, 32'hA1B2C3D4, 1'b0);
    xfer(1, 1'b0, 12'h7FF, 32'h0, 1, 32'd0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: ADDR_W, 12, word-address width.
REQ-002 Parameter: DEPTH, 1024, number of 32-bit words implemented; addresses at or above DEPTH are out of range.
REQ-003 Parameter: WAIT_CYCLES, 2, extra wait states per access; legal range 0-15.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 Port: MAX10_CLK1_50  input  1  clock.
REQ-006 Port: reset  input  1  asynchronous active-high reset.
REQ-007 Port: req_valid  input  1  CPU access request.
REQ-008 Port: req_ready  output  1  responder can accept a request.
REQ-009 Port: req_write  input  1  1=store, 0=load.
REQ-010 Port: req_addr  input  ADDR_W  word address.
REQ-011 Port: req_wdata  input  32  store data.
REQ-012 Port: rsp_valid  output  1  response available.
REQ-013 Port: rsp_ready  input  1  CPU accepts response.
REQ-014 Port: rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 Port: rsp_err  output  1  out-of-range access.
REQ-016 Port: led_out  output  8  MMIO LED register.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-018 Handshake: a request is accepted on a rising edge with req_valid&&req_ready; write, addr and wdata are captured at that edge.
REQ-019 Transitions: IDLE->WAIT on accept if WAIT_CYCLES>0, else IDLE->RESP; WAIT->RESP after exactly WAIT_CYCLES cycles; RESP->IDLE on rsp_ready.
REQ-020 Latency: accept at edge N gives rsp_valid=1 from edge N+1+WAIT_CYCLES.
REQ-021 Hold: rsp_valid, rsp_rdata and rsp_err stay stable until the rsp_ready edge; back-to-back requests are accepted at the earliest on the cycle after that edge.
REQ-022 Stores: write the memory once, on the WAIT->RESP (or IDLE->RESP) edge; no write when out of range.
REQ-023 Loads: rsp_rdata equals the memory word at the captured address; out-of-range gives rsp_rdata=0 and rsp_err=1.
REQ-024 Ordering: a load after a store to the same address returns the stored data.
REQ-025 Input changes while not in IDLE are ignored.

Reset
REQ-026 Reset forces state IDLE; req_ready=1 after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, led_out=0, wait counter=0.
REQ-027 Reset during WAIT or RESP abandons the access; a pending store is not performed.
REQ-028 Reset does not clear memory contents.

Configuration
REQ-029 Macro DMR_MMIO_LED_EN defined: address {ADDR_W{1'b1}} maps to the LED register. Stores set led_out=wdata[7:0]. Loads return {24'b0,led_out}. rsp_err=0. Memory is not touched.
REQ-030 Macro undefined: that address follows the normal range rule; led_out is tied to 0.

Structure
REQ-031 Package dmr_pkg holds the state enum, the MMIO address constant and the wait-counter width.
REQ-032 Sub-module dmr_sram: single-port synchronous 32-bit x DEPTH array with write enable; no reset.

Verification
REQ-033 WAIT_CYCLES=2: store 0xDEADBEEF to 0x005, then load 0x005 -> rsp_valid 3 cycles after each accept; load returns 0xDEADBEEF, rsp_err=0.
REQ-034 Load 0x400 (DEPTH=1024) -> rsp_err=1, rsp_rdata=0; store 0x400 -> memory unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0; rsp_ready=1 -> IDLE, next request accepted.
REQ-036 Assert reset during WAIT of a store of 0x12345678 to 0x010 -> state IDLE, rsp_valid=0; a later load of 0x010 returns the old value.
REQ-037 With DMR_MMIO_LED_EN: store 0x000000A5 to 0xFFF -> led_out=0xA5; load 0xFFF -> 0x000000A5. Without the macro: the same store gives rsp_err=1 and led_out=0.
REQ-038 WAIT_CYCLES=0: accept at edge N -> rsp_valid at edge N+1.
